// File: rtl/clock_disp_scan.sv
// clock_disp_scan: six-digit common-anode 7-segment scanner for an HH.MM.SS clock.
// Latency: one cycle from scan state (pre_cnt, idx, snapshot) to the registered pins.
// Backpressure: none; free-running scan driven from the counter-chain BCD digits.
//
// Ports:
//   maqh_clock          system clock
//   reset               asynchronous, active-low reset
//   h_msd..s_lsd        BCD time digits from the hour/minute/second counters
//   lz_blank            1 = blank the hours tens digit when it is 0 (sampled live)
//   enable_1hz          1 Hz one-cycle pulse, drives the blink phase
//   blink_sel           00 none, 01 hours, 10 minutes, 11 seconds
//   seg_n               segments {g,f,e,d,c,b,a}, active-low
//   dp_n                decimal point, active-low
//   dig_an_n            digit anodes, one-hot active-low, bit0 = s_lsd .. bit5 = h_msd
//
// Optional build macro: CLOCK_DISP_BLINK_EN adds the blink phase register; when
// it is undefined, enable_1hz and blink_sel are present but ignored.

module clock_disp_scan #(
   parameter int SCAN_DIV = 1000
) (
   input  logic       maqh_clock,
   input  logic       reset,
   input  logic [2:0] h_msd,
   input  logic [3:0] h_lsd,
   input  logic [2:0] m_msd,
   input  logic [3:0] m_lsd,
   input  logic [2:0] s_msd,
   input  logic [3:0] s_lsd,
   input  logic       lz_blank,
   input  logic       enable_1hz,
   input  logic [1:0] blink_sel,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] dig_an_n
);

   localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [6:0]     SEG_OFF  = 7'h7F;
   localparam logic [6:0]     SEG_DASH = 7'b0111111;

   // ------------------------------------------------------------------
   // Scan timing: prescaler and digit slot index
   // ------------------------------------------------------------------
   logic [PW-1:0] pre_cnt;
   logic [2:0]    idx;
   logic          tick;
   logic          frame_start;

   assign tick        = (pre_cnt == PRE_LAST);
   assign frame_start = (pre_cnt == '0) && (idx == 3'd0);

   always_ff @(posedge maqh_clock or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
         idx     <= 3'd0;
      end else if (tick) begin
         pre_cnt <= '0;
         idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Frame snapshot: taken on the dead cycle that opens each frame, so the
   // six digits shown within one frame always come from the same instant.
   // ------------------------------------------------------------------
   logic [2:0] snap_h_msd;
   logic [3:0] snap_h_lsd;
   logic [2:0] snap_m_msd;
   logic [3:0] snap_m_lsd;
   logic [2:0] snap_s_msd;
   logic [3:0] snap_s_lsd;

   always_ff @(posedge maqh_clock or negedge reset) begin
      if (!reset) begin
         snap_h_msd <= 3'd0;
         snap_h_lsd <= 4'd0;
         snap_m_msd <= 3'd0;
         snap_m_lsd <= 4'd0;
         snap_s_msd <= 3'd0;
         snap_s_lsd <= 4'd0;
      end else if (frame_start) begin
         snap_h_msd <= h_msd;
         snap_h_lsd <= h_lsd;
         snap_m_msd <= m_msd;
         snap_m_lsd <= m_lsd;
         snap_s_msd <= s_msd;
         snap_s_lsd <= s_lsd;
      end
   end

   // ------------------------------------------------------------------
   // Blink: a phase bit toggled at 1 Hz darkens the selected digit pair
   // ------------------------------------------------------------------
   logic [5:0] blink_mask;

`ifdef CLOCK_DISP_BLINK_EN
   logic blink_phase;

   always_ff @(posedge maqh_clock or negedge reset) begin
      if (!reset) begin
         blink_phase <= 1'b0;
      end else if (enable_1hz) begin
         blink_phase <= ~blink_phase;
      end
   end

   always_comb begin
      blink_mask = 6'b000000;
      if (blink_phase) begin
         case (blink_sel)
            2'b01:   blink_mask = 6'b110000;
            2'b10:   blink_mask = 6'b001100;
            2'b11:   blink_mask = 6'b000011;
            default: blink_mask = 6'b000000;
         endcase
      end
   end
`else
   logic unused_blink_inputs;

   assign unused_blink_inputs = ^{enable_1hz, blink_sel};
   assign blink_mask          = 6'b000000;
`endif

   // ------------------------------------------------------------------
   // Digit select and 7-segment decode
   // ------------------------------------------------------------------
   logic [3:0] cur_digit;
   logic [6:0] seg_dec;

   always_comb begin
      cur_digit = 4'd0;
      case (idx)
         3'd0:    cur_digit = snap_s_lsd;
         3'd1:    cur_digit = {1'b0, snap_s_msd};
         3'd2:    cur_digit = snap_m_lsd;
         3'd3:    cur_digit = {1'b0, snap_m_msd};
         3'd4:    cur_digit = snap_h_lsd;
         3'd5:    cur_digit = {1'b0, snap_h_msd};
         default: cur_digit = 4'd0;
      endcase
   end

   always_comb begin
      seg_dec = SEG_DASH;
      case (cur_digit)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = SEG_DASH;
      endcase
   end

   // ------------------------------------------------------------------
   // Next pin values. The first cycle of every slot is all-off so the
   // previous digit's segments never ghost onto the next anode.
   // ------------------------------------------------------------------
   logic [5:0] next_an;
   logic [6:0] next_seg;
   logic       next_dp;
   logic       lead_zero;

   assign lead_zero = (idx == 3'd5) && lz_blank && (snap_h_msd == 3'd0);

   always_comb begin
      next_an  = 6'b111111;
      next_seg = SEG_OFF;
      next_dp  = 1'b1;
      if (pre_cnt != '0) begin
         next_an  = ~(6'b000001 << idx) | blink_mask;
         next_seg = lead_zero ? SEG_OFF : seg_dec;
         // Separator dots after the hours and minutes units digits
         next_dp  = !((idx == 3'd2) || (idx == 3'd4));
      end
   end

   always_ff @(posedge maqh_clock or negedge reset) begin
      if (!reset) begin
         dig_an_n <= 6'b111111;
         seg_n    <= SEG_OFF;
         dp_n     <= 1'b1;
      end else begin
         dig_an_n <= next_an;
         seg_n    <= next_seg;
         dp_n     <= next_dp;
      end
   end

endmodule

// File: tb/tb_clock_disp_scan.sv
// tb_clock_disp_scan: directed bench for clock_disp_scan with SCAN_DIV = 4.
// Latency: expected pin values are queued per output cycle, one frame at a time.
// Backpressure: none; the bench pops one entry per clock on the falling edge.

module tb_clock_disp_scan;

   localparam int SCAN_DIV = 4;

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

`ifdef CLOCK_DISP_BLINK_EN
   localparam logic [5:0] BLINK_MIN = 6'b001100;
`else
   localparam logic [5:0] BLINK_MIN = 6'b000000;
`endif

   logic       maqh_clock = 1'b0;
   logic       reset      = 1'b0;
   logic [2:0] h_msd      = 3'd0;
   logic [3:0] h_lsd      = 4'd0;
   logic [2:0] m_msd      = 3'd0;
   logic [3:0] m_lsd      = 4'd0;
   logic [2:0] s_msd      = 3'd0;
   logic [3:0] s_lsd      = 4'd0;
   logic       lz_blank   = 1'b0;
   logic       enable_1hz = 1'b0;
   logic [1:0] blink_sel  = 2'b00;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] dig_an_n;

   int checks   = 0;
   int failures = 0;
   exp_t sb[$];

   clock_disp_scan #(.SCAN_DIV(SCAN_DIV)) dut (
      .maqh_clock (maqh_clock),
      .reset      (reset),
      .h_msd      (h_msd),
      .h_lsd      (h_lsd),
      .m_msd      (m_msd),
      .m_lsd      (m_lsd),
      .s_msd      (s_msd),
      .s_lsd      (s_lsd),
      .lz_blank   (lz_blank),
      .enable_1hz (enable_1hz),
      .blink_sel  (blink_sel),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .dig_an_n   (dig_an_n)
   );

   always #5 maqh_clock = ~maqh_clock;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Time as six nibbles, h_msd in the top nibble down to s_lsd in the bottom.
   task automatic set_time(input logic [23:0] t);
      h_msd = t[22:20];
      h_lsd = t[19:16];
      m_msd = t[14:12];
      m_lsd = t[11:8];
      s_msd = t[6:4];
      s_lsd = t[3:0];
   endtask

   // One frame of expected pins: per slot one all-off cycle, then three lit cycles.
   task automatic push_frame(input logic [23:0] t, input logic lz, input logic [5:0] dark);
      exp_t e;
      logic [3:0] d;
      for (int i = 0; i < 6; i++) begin
         e.an  = 6'b111111;
         e.seg = 7'h7F;
         e.dp  = 1'b1;
         sb.push_back(e);
         d     = t[4*i +: 4];
         e.an  = dark[i] ? 6'b111111 : ~(6'b000001 << i);
         e.seg = (i == 5 && lz && d == 4'd0) ? 7'h7F : dec(d);
         e.dp  = (i == 2 || i == 4) ? 1'b0 : 1'b1;
         for (int k = 1; k < SCAN_DIV; k++) sb.push_back(e);
      end
   endtask

   task automatic check_cycles(input int n, input string tag);
      exp_t e;
      for (int c = 0; c < n; c++) begin
         @(negedge maqh_clock);
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_underflow observed=empty expected=entry", tag);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_an"},  8'(dig_an_n), 8'(e.an));
            chk({tag, "_seg"}, 8'(seg_n),    8'(e.seg));
            chk({tag, "_dp"},  8'(dp_n),     8'(e.dp));
         end
      end
   endtask

   task automatic check_reset_pins(input string tag);
      chk({tag, "_an"},  8'(dig_an_n), 8'h3F);
      chk({tag, "_seg"}, 8'(seg_n),    8'h7F);
      chk({tag, "_dp"},  8'(dp_n),     8'h01);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge maqh_clock);
      check_reset_pins("rst");

      // Basic scan of 12:34:56, scanning starts right after release
      set_time(24'h123456);
      @(negedge maqh_clock);
      reset = 1'b1;
      push_frame(24'h123456, 1'b0, 6'b000000);
      check_cycles(24, "f_123456");

      // Inputs change while slot 3 is being shown: frame keeps the old time
      push_frame(24'h123456, 1'b0, 6'b000000);
      check_cycles(14, "tear_pre");
      set_time(24'h235959);
      check_cycles(10, "tear_post");
      push_frame(24'h235959, 1'b0, 6'b000000);
      check_cycles(24, "f_235959");

      // Leading-zero blanking on and off
      set_time(24'h050000);
      lz_blank = 1'b1;
      push_frame(24'h050000, 1'b1, 6'b000000);
      check_cycles(24, "lz_on");
      lz_blank = 1'b0;
      push_frame(24'h050000, 1'b0, 6'b000000);
      check_cycles(24, "lz_off");

      // Illegal seconds units digit shows a dash
      set_time(24'h05000C);
      push_frame(24'h05000C, 1'b0, 6'b000000);
      check_cycles(24, "illegal");

      // Blink minutes: dark after pulse 1, visible again after pulse 2
      set_time(24'h123456);
      blink_sel  = 2'b10;
      enable_1hz = 1'b1;
      push_frame(24'h123456, 1'b0, BLINK_MIN);
      check_cycles(1, "blink_on");
      enable_1hz = 1'b0;
      check_cycles(23, "blink_on");
      enable_1hz = 1'b1;
      push_frame(24'h123456, 1'b0, 6'b000000);
      check_cycles(1, "blink_off");
      enable_1hz = 1'b0;
      check_cycles(23, "blink_off");
      blink_sel = 2'b00;

      // Reset mid-frame at idx 4, pre_cnt 2, then a fresh frame on release
      push_frame(24'h123456, 1'b0, 6'b000000);
      check_cycles(18, "pre_rst");
      sb.delete();
      reset = 1'b0;
      #1;
      check_reset_pins("midrst");
      set_time(24'h235959);
      @(negedge maqh_clock);
      check_reset_pins("midrst_hold");
      reset = 1'b1;
      push_frame(24'h235959, 1'b0, 6'b000000);
      check_cycles(24, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
